// File: rtl/letter_seg_reader.sv
// Recovers 5-bit letter codes from a scanned, active-low 7-segment display.
// Per-digit debounce, code registers, and a valid/ready change-event port.
module letter_seg_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int STABLE_SCANS  = 3,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [0:6]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [DW-1:0]           ev_digit,
    output logic [4:0]              ev_code,
    output logic [5*NUM_DIGITS-1:0] codes,
    output logic                    err_multi
);
    localparam int STW = $clog2(SETTLE_CYCLES + 2);
    localparam int SW  = $clog2(STABLE_SCANS + 1);
    localparam logic [STW-1:0] SETTLE = STW'(SETTLE_CYCLES);
    localparam logic [SW-1:0]  STABLE = SW'(STABLE_SCANS);

    logic [0:6]                      seg_r;
    logic [NUM_DIGITS-1:0]           an_r;
    logic [STW-1:0]                  settle;
    logic [NUM_DIGITS-1:0][4:0]      code_q;
    logic [NUM_DIGITS-1:0][4:0]      cand_q;
    logic [NUM_DIGITS-1:0][SW-1:0]   cnt_q;
    logic [NUM_DIGITS-1:0]           pend;

    logic [4:0]            dec;
    logic [NUM_DIGITS-1:0] an_low, pend_set, pend_clr;
    logic                  sample_pt, one_hot, take, multi, match, accept, free, ld_any;
    logic [DW-1:0]         sel, ld_d;
    logic [SW-1:0]         cnt_cur, cnt_new;

    assign codes = code_q;

    function automatic logic [4:0] decode(input logic [0:6] raw);
        logic [0:6] p;
        p = ~raw;
        if (raw == 7'b0101010) return 5'd31;
        case (p)
            7'b1110111: return 5'd0;
            7'b0011111: return 5'd1;
            7'b1011000: return 5'd2;
            7'b0111101: return 5'd3;
            7'b1001111: return 5'd4;
            7'b1000111: return 5'd5;
            7'b1011110: return 5'd6;
            7'b0110111: return 5'd7;
            7'b0111100: return 5'd8;
            7'b0001110: return 5'd9;
            7'b0010101: return 5'd10;
            7'b0011101: return 5'd11;
            7'b1100111: return 5'd12;
            7'b0000101: return 5'd13;
            7'b1011011: return 5'd14;
            7'b0111011: return 5'd15;
            7'b0000000: return 5'd29;
            default:    return 5'd30;
        endcase
    endfunction

    always_comb begin
        dec       = decode(seg_r);
        an_low    = ~an_r;
        sample_pt = (settle == SETTLE);
        one_hot   = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
        sel = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (an_low[i]) sel = DW'(i);
        take    = sample_pt && one_hot;
        multi   = sample_pt && !one_hot && (an_low != '0);
        match   = (dec == cand_q[sel]);
        cnt_cur = cnt_q[sel];
        if (!match)                cnt_new = SW'(1);
        else if (cnt_cur == STABLE) cnt_new = STABLE;
        else                       cnt_new = cnt_cur + SW'(1);
        // Accept only on the transition into STABLE, never while saturated.
        accept = take && (cnt_new == STABLE) && !(match && cnt_cur == STABLE)
                 && (dec != code_q[sel]);
        pend_set = '0;
        if (accept) pend_set[sel] = 1'b1;
        free   = !ev_valid || ev_ready;
        ld_any = |pend;
        ld_d   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--)
            if (pend[i]) ld_d = DW'(i);
        pend_clr = '0;
        if (free && ld_any) pend_clr[ld_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r     <= '1;
            an_r      <= '1;
            settle    <= '0;
            code_q    <= {NUM_DIGITS{5'd29}};
            cand_q    <= {NUM_DIGITS{5'd29}};
            cnt_q     <= '0;
            pend      <= '0;
            ev_valid  <= 1'b0;
            ev_digit  <= '0;
            ev_code   <= '0;
            err_multi <= 1'b0;
        end else begin
            seg_r <= seg_n;
            an_r  <= an_n;
            // Counter runs to SETTLE+1 so the sample point occurs once per activation.
            if (an_n != an_r)          settle <= '0;
            else if (settle <= SETTLE) settle <= settle + STW'(1);
            err_multi <= multi;
            if (take) begin
                cand_q[sel] <= dec;
                cnt_q[sel]  <= cnt_new;
                if (accept) code_q[sel] <= dec;
            end
            pend <= (pend & ~pend_clr) | pend_set;
            if (free) begin
                if (ld_any) begin
                    ev_valid <= 1'b1;
                    ev_digit <= ld_d;
                    ev_code  <= code_q[ld_d];
                end else begin
                    ev_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_letter_seg_reader.sv
// Randomized + directed bench for letter_seg_reader against a scan-level reference model.
module tb_letter_seg_reader;
    localparam int ND = 4;
    localparam int SC = 2;
    localparam int SS = 3;
    localparam int H  = SC + 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [0:6]      seg_n = '1;
    logic [ND-1:0]   an_n = '1;
    logic            ev_ready = 1'b1;
    logic            ev_valid;
    logic [1:0]      ev_digit;
    logic [4:0]      ev_code;
    logic [5*ND-1:0] codes;
    logic            err_multi;

    always #5 clk = ~clk;

    letter_seg_reader #(.NUM_DIGITS(ND), .SETTLE_CYCLES(SC), .STABLE_SCANS(SS)) dut (
        .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_digit(ev_digit),
        .ev_code(ev_code), .codes(codes), .err_multi(err_multi)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    // Reference model: decode by table lookup, debounce per scan.
    logic [0:6] tbl [0:15];
    int mcode [ND];
    int mcand [ND];
    int mcnt  [ND];
    int exp_q [$];
    int obs_q [$];
    int errcnt = 0;
    logic [0:6] lastp [ND];

    always @(posedge clk) begin
        if (!rst && ev_valid && ev_ready) obs_q.push_back(int'({ev_digit, ev_code}));
        if (err_multi) errcnt <= errcnt + 1;
    end

    function automatic int model_dec(input logic [0:6] raw);
        logic [0:6] p;
        p = ~raw;
        if (raw == 7'b0101010) return 31;
        if (p == 7'b0000000) return 29;
        for (int k = 0; k < 16; k++) if (p == tbl[k]) return k;
        return 30;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            mcode[d] = 29; mcand[d] = 29; mcnt[d] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_sample(input int d, input logic [0:6] raw);
        int c;
        c = model_dec(raw);
        if (c == mcand[d]) begin
            if (mcnt[d] < SS) begin
                mcnt[d]++;
                if (mcnt[d] == SS && c != mcode[d]) begin
                    mcode[d] = c; exp_q.push_back(d * 32 + c);
                end
            end
        end else begin
            mcand[d] = c;
            mcnt[d]  = 1;
            if (mcnt[d] == SS && c != mcode[d]) begin
                mcode[d] = c; exp_q.push_back(d * 32 + c);
            end
        end
    endtask

    function automatic logic [31:0] exp_codes();
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < ND; d++) r |= 32'(mcode[d]) << (5 * d);
        return r;
    endfunction

    task automatic cmp_events(input string tag);
        chk({tag, "_ev_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk({tag, "_ev"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // One activation then an equal-length blank gap.
    task automatic drive(input logic [ND-1:0] an, input logic [0:6] raw);
        @(negedge clk);
        an_n = an; seg_n = raw;
        repeat (H - 1) @(negedge clk);
        an_n = '1; seg_n = '1;
        repeat (H) @(negedge clk);
    endtask

    task automatic scan(input string tag, input int d, input logic [0:6] raw, input bit do_ev);
        drive(~(ND'(1) << d), raw);
        model_sample(d, raw);
        chk({tag, "_codes"}, 32'(codes), exp_codes());
        if (do_ev) cmp_events(tag);
    endtask

    initial begin
        int e0, m, r, a, b;
        logic [ND-1:0] an;
        logic [0:6] raw;
        tbl = '{7'b1110111, 7'b0011111, 7'b1011000, 7'b0111101,
                7'b1001111, 7'b1000111, 7'b1011110, 7'b0110111,
                7'b0111100, 7'b0001110, 7'b0010101, 7'b0011101,
                7'b1100111, 7'b0000101, 7'b1011011, 7'b0111011};
        model_reset();
        for (int d = 0; d < ND; d++) lastp[d] = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_codes", 32'(codes), exp_codes());
        chk("rst_valid", ev_valid, 0);
        chk("rst_digit", ev_digit, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_err", err_multi, 0);

        for (int i = 0; i < 3; i++) scan("blank", 1, '1, 1);
        for (int i = 0; i < 5; i++) scan("d0_zero", 0, ~7'b1110111, 1);

        scan("d1_a", 1, ~7'b0011111, 1);
        scan("d1_b", 1, ~7'b0011111, 1);
        scan("d1_glitch", 1, ~7'b1011000, 1);
        for (int i = 0; i < 3; i++) scan("d1_c", 1, ~7'b0011111, 1);

        scan("p_all", 3, 7'b0000000, 1);
        scan("p_all", 3, 7'b0000000, 1);
        scan("p_all", 3, 7'b0000000, 1);
        for (int i = 0; i < 3; i++) scan("marker", 3, 7'b0101010, 1);

        // Back-pressure: two events queued, lowest digit first.
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) scan("bp_d0", 0, ~7'b1001111, 0);
        for (int i = 0; i < 3; i++) scan("bp_d2", 2, ~7'b0000101, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", ev_valid, 1);
            chk("hold_digit", ev_digit, 0);
            chk("hold_code", ev_code, 4);
        end
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        chk("next_valid", ev_valid, 1);
        chk("next_digit", ev_digit, 2);
        chk("next_code", ev_code, 13);
        ev_ready = 1'b1;
        @(negedge clk);
        chk("drain_valid", ev_valid, 0);
        cmp_events("bp");

        e0 = errcnt;
        drive(4'b1100, ~tbl[3]);
        chk("multi_pulse", errcnt - e0, 1);
        chk("multi_codes", 32'(codes), exp_codes());
        cmp_events("multi");

        // Reset with an event outstanding and another pending.
        ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) scan("pre_rst0", 0, ~tbl[5], 0);
        for (int i = 0; i < 3; i++) scan("pre_rst1", 1, ~tbl[7], 0);
        chk("pre_rst_valid", ev_valid, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
        chk("post_rst_valid", ev_valid, 0);
        chk("post_rst_codes", 32'(codes), exp_codes());
        chk("no_hs_before_rst", obs_q.size(), 0);
        obs_q.delete();
        ev_ready = 1'b1;
        for (int i = 0; i < 3; i++) scan("post_rst", 0, ~tbl[5], 1);

        for (int it = 0; it < 200; it++) begin
            m = $urandom_range(0, 9);
            if (m == 0) begin
                drive('1, 7'($urandom));
                chk("rnd_blank_codes", 32'(codes), exp_codes());
                cmp_events("rnd_blank");
            end else if (m == 1) begin
                a = $urandom_range(0, ND - 1);
                b = (a + $urandom_range(1, ND - 1)) % ND;
                an = ND'($urandom) & ~(ND'(1) << a) & ~(ND'(1) << b);
                e0 = errcnt;
                drive(an, 7'($urandom));
                chk("rnd_multi_pulse", errcnt - e0, 1);
                chk("rnd_multi_codes", 32'(codes), exp_codes());
                cmp_events("rnd_multi");
            end else begin
                a = $urandom_range(0, ND - 1);
                if ($urandom_range(0, 3) != 0) raw = lastp[a];
                else begin
                    r = $urandom_range(0, 9);
                    if (r <= 5)      raw = ~tbl[$urandom_range(0, 15)];
                    else if (r == 6) raw = '1;
                    else if (r == 7) raw = 7'b0101010;
                    else if (r == 8) raw = '0;
                    else             raw = 7'($urandom);
                end
                lastp[a] = raw;
                scan("rnd", a, raw, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/letter_seg_reader.md
Name: letter_seg_reader

Overview:
- Reads back a multiplexed, active-low 7-segment letter display and recovers the 5-bit letter code shown on each digit.
- Used as the capture/checker end of the letter display path, and to recover codes from an external scanned display.
- Samples the segment bus once per digit activation, debounces per digit, keeps a code register per digit, and reports changes through a valid/ready event port.

Parameters:
NUM_DIGITS, 4, number of scanned digits (anode lines); digit index width DW = clog2(NUM_DIGITS)
SETTLE_CYCLES, 2, cycles an anode selection must be held before the segment bus is sampled
STABLE_SCANS, 3, consecutive identical decodes on one digit needed to accept a new code (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
seg_n  in  [0:6]  segment bus, active-low; bit 0 = segment a ... bit 6 = segment g
an_n  in  NUM_DIGITS  digit enables, active-low
ev_valid  out  1  change event available
ev_ready  in  1  consumer accepts event
ev_digit  out  DW  digit index of event
ev_code  out  5  accepted code of that digit
codes  out  5*NUM_DIGITS  current accepted code per digit; digit d at [5d+4:5d]
err_multi  out  1  one-cycle pulse: more than one anode low at a sample point

Behaviour:
- Reset: all outputs and state clear on the clock edge where rst=1. codes = 29 for every digit, candidates = 29, counts = 0, pending = 0, settle counter = 0, ev_valid = 0, ev_digit = 0, ev_code = 0, err_multi = 0.
- Reset mid-event drops the event; no handshake completes.
- Input stage: seg_n and an_n are registered once. All logic below uses the registered copies.
- Settle: any change of registered an_n zeroes the settle counter. The counter increments while an_n is unchanged and saturates.
- Sample point: exactly one cycle per activation, the cycle in which the counter equals SETTLE_CYCLES.
- Sample point classification:
  - Exactly one an_n bit low: sample taken for that digit.
  - All an_n bits high: blanking; no sample.
  - More than one bit low: err_multi=1 for that cycle; no sample.
- Decode (combinational). Let p = ~seg_n, active-high, bit 0 = a. p is matched to a code as follows:
  - 1110111 -> 0
  - 0011111 -> 1
  - 1011000 -> 2
  - 0111101 -> 3
  - 1001111 -> 4
  - 1000111 -> 5
  - 1011110 -> 6
  - 0110111 -> 7
  - 0111100 -> 8
  - 0001110 -> 9
  - 0010101 -> 10
  - 0011101 -> 11
  - 1100111 -> 12
  - 0000101 -> 13
  - 1011011 -> 14
  - 0111011 -> 15
  - Raw seg_n == 0101010 (invalid-letter marker) -> 31
  - p == 0000000 (blank) -> 29
  - Any other pattern -> 30
- Per-digit debounce, applied at a sample on digit d:
  - If decode == cand[d], count[d] increments, saturating at STABLE_SCANS.
  - Otherwise cand[d] = decode and count[d] = 1.
- Acceptance: on the sample where count[d] becomes STABLE_SCANS (transition only, not while saturated) and cand[d] != codes[d], set codes[d] = cand[d] and pending[d] = 1.
- If the candidate equals the current code, nothing happens.
- Event port:
  - The output register is free when ev_valid=0, or when ev_valid=1 and ev_ready=1.
  - When free and any pending bit is set, load the lowest-index pending digit d: ev_valid=1, ev_digit=d, ev_code=codes[d], and clear pending[d].
  - When free and nothing is pending, ev_valid becomes 0.
  - ev_digit and ev_code are held constant while ev_valid=1 and ev_ready=0.
- Coalescing: if codes[d] changes again while pending[d]=1, a single event carries the latest code.
- Simultaneous set and clear of pending[d] in one cycle: set wins.
- Latency: the qualifying sample is registered in cycle N.
  - codes and pending update at the end of N (visible in N+1).
  - ev_valid rises in N+2 if the output register is free.
  - Back-to-back events are possible with ev_ready held high: one per cycle.

Test Plan:
- Digit 0 activated (an_n=1110, >=SETTLE_CYCLES+1 cycles per activation), seg_n=~1110111 for 3 scans -> codes[4:0]=0 after 3rd sample; exactly one event {digit 0, code 0}; further identical scans produce no event.
- Digit 1 shows ~0011111 for 2 scans, then one scan of ~1011000, then ~0011111 again -> no event until 3 consecutive matches; then one event {1,1}; codes[9:5] never equals 2.
- ev_ready=0; digit 0 changes to code 4 (1001111) and digit 2 to code 13 (0000101) -> ev_valid holds {0,4} stable; after one ready cycle, next event {2,13}; after that ev_valid=0.
- an_n=1100 at a sample point -> err_multi pulses 1 cycle; codes, counts and pending unchanged.
- Pattern p=1111111 for 3 scans -> code 30. Raw seg_n=0101010 for 3 scans -> code 31. seg_n=1111111 -> code 29, no event from reset state.
- Assert rst while ev_valid=1 and pending bits set -> next cycle ev_valid=0 and all codes=29; no event until 3 new stable scans.
